// File: rtl/pool_pkg.sv
// Shared definitions for the max-pool stages: FSM states, map geometry
// constants and the signed int8 max helper.
package pool_pkg;

  localparam int unsigned IN_WORDS_PER_ROW = 7;
  localparam int unsigned OUT_DIM          = 7;
  localparam int unsigned LAST_PIXEL       = 48;
  localparam int unsigned LAST_WORD        = 24;

  typedef enum logic [2:0] {
    IDLE,
    RD_T,
    RD_B,
    REDUCE,
    WRITE,
    DONE
  } pool_state_e;

  function automatic logic [7:0] smax8(input logic [7:0] a, input logic [7:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_stage_if.sv
// Run/busy handshake plus output-SRAM read port and scratchpad write port
// of the max-pool stage.
interface maxpool_stage_if;
  logic        pool_run;
  logic        pool_busy;
  logic [11:0] output_sram_read_address;
  logic [15:0] output_sram_read_data;
  logic        scratchpad_sram_write_enable;
  logic [11:0] scratchpad_sram_write_addresss;
  logic [15:0] scratchpad_sram_write_data;

  modport master (
    input  pool_run,
    output pool_busy,
    output output_sram_read_address,
    input  output_sram_read_data,
    output scratchpad_sram_write_enable,
    output scratchpad_sram_write_addresss,
    output scratchpad_sram_write_data
  );

  modport slave (
    output pool_run,
    input  pool_busy,
    input  output_sram_read_address,
    output output_sram_read_data,
    input  scratchpad_sram_write_enable,
    input  scratchpad_sram_write_addresss,
    input  scratchpad_sram_write_data
  );
endinterface

// File: rtl/maxpool_stage_max4_s8.sv
// Combinational signed maximum of four int8 values.
module max4_s8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [7:0] d,
  output logic [7:0] y
);
  import pool_pkg::*;

  always_comb begin
    y = smax8(smax8(a, b), smax8(c, d));
  end
endmodule

// File: rtl/maxpool_stage.sv
// 2x2 stride-2 signed max-pool of a 14x14 int8 map into a 7x7 map,
// packed two pooled pixels per scratchpad word.
module maxpool_stage #(
  parameter logic [11:0] RD_BASE_ADDR     = 12'h000,
  parameter logic [11:0] SP_BASE_ADDR     = 12'h000,
  parameter int unsigned IN_WORDS_PER_ROW = 7,
  parameter int unsigned OUT_DIM          = 7
) (
  input  logic           clk,
  input  logic           reset_b,
  maxpool_stage_if.master pool
);
  import pool_pkg::*;

  localparam logic [2:0]  LAST_IDX   = 3'(OUT_DIM - 1);
  localparam logic [11:0] ROW_STRIDE = 12'(IN_WORDS_PER_ROW);
  localparam logic [11:0] WIN_STRIDE = 12'(2 * IN_WORDS_PER_ROW);

  pool_state_e state;
  logic [2:0]  i, j;
  logic [4:0]  k;
  logic        p_odd;
  logic [7:0]  partial, hold_hi, reduced;
  logic [2:0]  next_i, next_j;
  logic        at_last;
  logic [11:0] top_addr, next_top_addr;

  max4_s8 u_max4 (
    .a(partial),
    .b(pool.output_sram_read_data[15:8]),
    .c(pool.output_sram_read_data[7:0]),
    .d(partial),
    .y(reduced)
  );

  always_comb begin
    at_last = (i == LAST_IDX) && (j == LAST_IDX);
    next_i  = i;
    next_j  = j + 3'd1;
    if (j == LAST_IDX) begin
      next_i = i + 3'd1;
      next_j = '0;
    end
    top_addr      = RD_BASE_ADDR + WIN_STRIDE * 12'(i) + 12'(j);
    next_top_addr = RD_BASE_ADDR + WIN_STRIDE * 12'(next_i) + 12'(next_j);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state                              <= IDLE;
      pool.pool_busy                     <= 1'b0;
      pool.output_sram_read_address      <= RD_BASE_ADDR;
      pool.scratchpad_sram_write_enable  <= 1'b0;
      pool.scratchpad_sram_write_addresss <= SP_BASE_ADDR;
      pool.scratchpad_sram_write_data    <= '0;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      p_odd   <= 1'b0;
      partial <= '0;
      hold_hi <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pool.pool_run) begin
            pool.pool_busy                <= 1'b1;
            pool.output_sram_read_address <= top_addr;
            state                         <= RD_T;
          end
        end
        RD_T: begin
          pool.output_sram_read_address <= top_addr + ROW_STRIDE;
          state                         <= RD_B;
        end
        RD_B: begin
          partial <= smax8(pool.output_sram_read_data[15:8], pool.output_sram_read_data[7:0]);
          state   <= REDUCE;
        end
        REDUCE: begin
          if (!p_odd && !at_last) begin
            hold_hi                       <= reduced;
            i                             <= next_i;
            j                             <= next_j;
            p_odd                         <= ~p_odd;
            pool.output_sram_read_address <= next_top_addr;
            state                         <= RD_T;
          end else begin
            // Pixel 48 is even and lands alone in the high byte of the last word.
            pool.scratchpad_sram_write_enable <= 1'b1;
            pool.scratchpad_sram_write_data   <= p_odd ? {hold_hi, reduced} : {reduced, 8'h00};
            state                             <= WRITE;
          end
        end
        WRITE: begin
          pool.scratchpad_sram_write_enable <= 1'b0;
          if (at_last) begin
            state <= DONE;
          end else begin
            i                                   <= next_i;
            j                                   <= next_j;
            p_odd                               <= ~p_odd;
            k                                   <= k + 5'd1;
            pool.scratchpad_sram_write_addresss <= SP_BASE_ADDR + 12'(k) + 12'd1;
            pool.output_sram_read_address       <= next_top_addr;
            state                               <= RD_T;
          end
        end
        DONE: begin
          pool.pool_busy                      <= 1'b0;
          i                                   <= '0;
          j                                   <= '0;
          k                                   <= '0;
          p_odd                               <= 1'b0;
          pool.output_sram_read_address       <= RD_BASE_ADDR;
          pool.scratchpad_sram_write_addresss <= SP_BASE_ADDR;
          state                               <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
